// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin front end for the SDRAM controller: issues one request at a time,
// routes returned read data back to the issuing port, and flags a controller that never acks.
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH  = 23,
    parameter int DATA_WIDTH  = 32,
    parameter int RD_LATENCY  = 12,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ctl_req,
    output logic                  ctl_we,
    output logic [ADDR_WIDTH-1:0] ctl_addr,
    output logic [DATA_WIDTH-1:0] ctl_wdata,
    input  logic                  ctl_ack,
    input  logic [DATA_WIDTH-1:0] ctl_rd_data,
    output logic                  err
);

    localparam int CW   = $clog2(ACK_TIMEOUT + 1);
    localparam int LAST = RD_LATENCY - 1;
    localparam logic [CW-1:0] TMO_MAX = CW'(ACK_TIMEOUT);
    localparam logic [CW-1:0] TMO_ERR = CW'(ACK_TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_owner_q, last_owner_d;
    logic                    ctl_req_q, ctl_req_d;
    logic                    ctl_we_q, ctl_we_d;
    logic [ADDR_WIDTH-1:0]   ctl_addr_q, ctl_addr_d;
    logic [DATA_WIDTH-1:0]   ctl_wdata_q, ctl_wdata_d;
    logic                    err_q, err_d;
    logic [CW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic [RD_LATENCY-1:0]   tag_valid_q, tag_valid_d;
    logic [RD_LATENCY-1:0]   tag_port_q, tag_port_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rvalid0_q, rvalid0_d;
    logic                    rvalid1_q, rvalid1_d;

    logic ack_ok;
    logic any_req;
    logic winner;

    // An ack only counts while a request is outstanding; stray acks in IDLE are dropped.
    assign ack_ok  = ctl_ack && (state_q == ISSUE);
    assign any_req = p0_req | p1_req;
    assign winner  = (p0_req && p1_req) ? ~last_owner_q : p1_req;

    assign p0_gnt    = ack_ok & ~owner_q;
    assign p1_gnt    = ack_ok & owner_q;
    assign p0_rvalid = rvalid0_q;
    assign p1_rvalid = rvalid1_q;
    assign rdata     = rdata_q;
    assign ctl_req   = ctl_req_q;
    assign ctl_we    = ctl_we_q;
    assign ctl_addr  = ctl_addr_q;
    assign ctl_wdata = ctl_wdata_q;
    assign err       = err_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        ctl_req_d    = ctl_req_q;
        ctl_we_d     = ctl_we_q;
        ctl_addr_d   = ctl_addr_q;
        ctl_wdata_d  = ctl_wdata_q;
        err_d        = err_q;
        tmo_cnt_d    = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d     = winner;
                    ctl_we_d    = winner ? p1_we    : p0_we;
                    ctl_addr_d  = winner ? p1_addr  : p0_addr;
                    ctl_wdata_d = winner ? p1_wdata : p0_wdata;
                    ctl_req_d   = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // Counter saturates; the request keeps waiting even after err is raised.
                if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
                if (tmo_cnt_q == TMO_ERR) begin
                    err_d = 1'b1;
                end
                if (ctl_ack) begin
                    ctl_req_d    = 1'b0;
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-return tag pipe: {valid, port} travels alongside the controller's read latency.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_d[gi] = ack_ok & ~ctl_we_q;
                assign tag_port_d[gi]  = owner_q;
            end else begin : g_shift
                assign tag_valid_d[gi] = tag_valid_q[gi-1];
                assign tag_port_d[gi]  = tag_port_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        rvalid0_d = tag_valid_q[LAST] & ~tag_port_q[LAST];
        rvalid1_d = tag_valid_q[LAST] & tag_port_q[LAST];
        rdata_d   = tag_valid_q[LAST] ? ctl_rd_data : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            ctl_req_q    <= 1'b0;
            ctl_we_q     <= 1'b0;
            ctl_addr_q   <= '0;
            ctl_wdata_q  <= '0;
            err_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            tag_valid_q  <= '0;
            tag_port_q   <= '0;
            rdata_q      <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            ctl_req_q    <= ctl_req_d;
            ctl_we_q     <= ctl_we_d;
            ctl_addr_q   <= ctl_addr_d;
            ctl_wdata_q  <= ctl_wdata_d;
            err_q        <= err_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tag_valid_q  <= tag_valid_d;
            tag_port_q   <= tag_port_d;
            rdata_q      <= rdata_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
        end
    end

endmodule
